// File: rtl/dot_engine_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : dot_engine_pkg
// Purpose  : Shared types and helpers for the dot-product engine.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package dot_engine_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SAT_NONE = 2'd0,
      SAT_MAX  = 2'd1,
      SAT_MIN  = 2'd2
   } sat_e;

   // Wide enough for N_ELEM full products in either signedness plus a sign bit.
   function automatic int acc_width(input int n_elem, input int elem_w);
      return 2 * elem_w + $clog2(n_elem) + 1;
   endfunction

   function automatic sat_e sat_select(input logic ovf, input logic negative);
      if (!ovf)
         return SAT_NONE;
      return negative ? SAT_MIN : SAT_MAX;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dot_lane_mult.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : dot_lane_mult
// Purpose  : LANES signed/unsigned multipliers summed into one ACC_W value.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module dot_lane_mult
   import dot_engine_pkg::*;
#(
   parameter int LANES  = 1,
   parameter int ELEM_W = 32,
   parameter int ACC_W  = 67
) (
   input  logic [LANES*ELEM_W-1:0] a_lanes,
   input  logic [LANES*ELEM_W-1:0] b_lanes,
   input  logic                    is_signed,
   output logic [ACC_W-1:0]        lane_sum
);

   logic signed [ACC_W-1:0] w_prod [LANES];

   // One extra bit turns both signednesses into a single signed multiply.
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic signed [ELEM_W:0] w_ea;
      logic signed [ELEM_W:0] w_eb;
      assign w_ea = {is_signed & a_lanes[g*ELEM_W+ELEM_W-1], a_lanes[g*ELEM_W +: ELEM_W]};
      assign w_eb = {is_signed & b_lanes[g*ELEM_W+ELEM_W-1], b_lanes[g*ELEM_W +: ELEM_W]};
      assign w_prod[g] = ACC_W'(w_ea) * ACC_W'(w_eb);
   end

   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < LANES; i++)
         lane_sum = lane_sum + w_prod[i];
   end

endmodule
`default_nettype wire

// File: rtl/dot_product_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : dot_product_engine
// Purpose  : Multi-cycle vector dot product with wrap/saturate output stage.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module dot_product_engine
   import dot_engine_pkg::*;
#(
   parameter int N_ELEM   = 4,
   parameter int ELEM_W   = 32,
   parameter int LANES    = 1,
   parameter int OUT_W    = 32,
   parameter bit SATURATE = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_signed,
   input  logic [N_ELEM*ELEM_W-1:0] vec_a,
   input  logic [N_ELEM*ELEM_W-1:0] vec_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUT_W-1:0]         dot_result,
   output logic                     overflow
);

   localparam int c_beats  = N_ELEM / LANES;
   localparam int c_acc_w  = acc_width(N_ELEM, ELEM_W);
   localparam int c_lane_w = LANES * ELEM_W;
   localparam int c_vec_w  = N_ELEM * ELEM_W;
   localparam int c_beat_w = $clog2(c_beats + 1);
   localparam int c_ext_w  = (c_acc_w > OUT_W) ? c_acc_w : OUT_W + 1;

   if (N_ELEM % LANES != 0) begin : g_lanes_check
      $error("dot_product_engine: N_ELEM must be a multiple of LANES");
   end

   state_e                r_state;
   logic [c_beat_w-1:0]   r_beat;
   logic [c_vec_w-1:0]    r_vec_a;
   logic [c_vec_w-1:0]    r_vec_b;
   logic                  r_signed;
   logic [c_acc_w-1:0]    r_acc;
   logic [OUT_W-1:0]      r_result;
   logic                  r_overflow;
   logic                  r_out_valid;

   logic                  w_accept;
   logic [c_acc_w-1:0]    w_lane_sum;
   logic signed [c_ext_w-1:0] w_acc_ext;
   logic [c_ext_w-OUT_W:0] w_hi_s;
   logic                  w_ovf;
   logic [OUT_W-1:0]      w_result;

   assign in_ready   = (r_state == IDLE) | ((r_state == DONE) & out_ready);
   assign w_accept   = in_valid & in_ready;
   assign out_valid  = r_out_valid;
   assign dot_result = r_result;
   assign overflow   = r_overflow;

   // Operand registers shift down each beat, so lane 0 always sits at the bottom.
   dot_lane_mult #(
      .LANES  (LANES),
      .ELEM_W (ELEM_W),
      .ACC_W  (c_acc_w)
   ) u_lane_mult (
      .a_lanes   (r_vec_a[c_lane_w-1:0]),
      .b_lanes   (r_vec_b[c_lane_w-1:0]),
      .is_signed (r_signed),
      .lane_sum  (w_lane_sum)
   );

   // The accumulator is two's complement in both modes (unsigned sums stay non-negative).
   assign w_acc_ext = c_ext_w'($signed(r_acc));
   assign w_hi_s    = w_acc_ext[c_ext_w-1:OUT_W-1];
   assign w_ovf     = r_signed ? ~((&w_hi_s) | ~(|w_hi_s))
                               : (|w_acc_ext[c_ext_w-1:OUT_W]);

   always_comb begin
      w_result = w_acc_ext[OUT_W-1:0];
      if (SATURATE) begin
         case (sat_select(w_ovf, w_acc_ext[c_ext_w-1]))
            SAT_MAX: w_result = r_signed ? {1'b0, {(OUT_W-1){1'b1}}} : {OUT_W{1'b1}};
            SAT_MIN: w_result = r_signed ? {1'b1, {(OUT_W-1){1'b0}}} : {OUT_W{1'b0}};
            default: w_result = w_acc_ext[OUT_W-1:0];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_beat      <= '0;
         r_vec_a     <= '0;
         r_vec_b     <= '0;
         r_signed    <= 1'b0;
         r_acc       <= '0;
         r_result    <= '0;
         r_overflow  <= 1'b0;
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_state     <= RUN;
         r_beat      <= '0;
         r_vec_a     <= vec_a;
         r_vec_b     <= vec_b;
         r_signed    <= in_signed;
         r_acc       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               if (r_beat == c_beat_w'(c_beats)) begin
                  r_result    <= w_result;
                  r_overflow  <= w_ovf;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_acc   <= r_acc + w_lane_sum;
                  r_beat  <= r_beat + 1'b1;
                  r_vec_a <= r_vec_a >> c_lane_w;
                  r_vec_b <= r_vec_b >> c_lane_w;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            IDLE: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dot_product_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_dot_product_engine
// Purpose  : Scoreboard bench for a default engine and an 8x2-lane saturating one.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_dot_product_engine;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid  [2];
   logic        in_ready  [2];
   logic        in_signed [2];
   logic        out_valid [2];
   logic        out_ready [2];
   logic        overflow  [2];
   logic [31:0] dot_result[2];
   logic [255:0] va[2];
   logic [255:0] vb[2];

   always #5 clk = ~clk;

   dot_product_engine u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_signed(in_signed[0]),
      .vec_a(va[0][127:0]), .vec_b(vb[0][127:0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .dot_result(dot_result[0]), .overflow(overflow[0])
   );

   dot_product_engine #(.N_ELEM(8), .LANES(2), .SATURATE(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_signed(in_signed[1]),
      .vec_a(va[1]), .vec_b(vb[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .dot_result(dot_result[1]), .overflow(overflow[1])
   );

   typedef struct packed {
      logic [31:0] res;
      logic        ovf;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   acc_cyc [2];
   logic prev_v  [2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic exp_t model(input int n, input bit sat, input logic [255:0] a,
                                  input logic [255:0] b, input logic sgn);
      logic signed [127:0] s, ea, eb;
      logic signed [127:0] smax, smin, umax;
      exp_t e;
      s    = '0;
      smax = 128'sd2147483647;
      smin = -128'sd2147483648;
      umax = 128'sd4294967295;
      for (int i = 0; i < n; i++) begin
         ea = sgn ? {{96{a[32*i+31]}}, a[32*i +: 32]} : {96'b0, a[32*i +: 32]};
         eb = sgn ? {{96{b[32*i+31]}}, b[32*i +: 32]} : {96'b0, b[32*i +: 32]};
         s  = s + ea * eb;
      end
      e.ovf = sgn ? ((s > smax) || (s < smin)) : (s > umax);
      e.res = s[31:0];
      if (sat && e.ovf)
         e.res = sgn ? ((s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF) : 32'hFFFF_FFFF;
      return e;
   endfunction

   function automatic logic [255:0] pk4(input logic [31:0] e0, input logic [31:0] e1,
                                        input logic [31:0] e2, input logic [31:0] e3);
      return {128'b0, e3, e2, e1, e0};
   endfunction

   task automatic mon(input int i);
      exp_t e;
      bit   have;
      if (out_valid[i] && !prev_v[i])
         check($sformatf("latency%0d", i), 64'(cyc - acc_cyc[i]), 64'd5);
      if (out_valid[i]) begin
         have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
         if (!have) begin
            check($sformatf("unexpected_out%0d", i), 64'd1, 64'd0);
         end else begin
            e = (i == 0) ? q0[0] : q1[0];
            check($sformatf("result%0d", i), 64'(dot_result[i]), 64'(e.res));
            check($sformatf("ovf%0d", i), 64'(overflow[i]), 64'(e.ovf));
            if (out_ready[i]) begin
               if (i == 0) void'(q0.pop_front());
               else        void'(q1.pop_front());
            end
         end
      end
      prev_v[i] = out_valid[i];
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(0);
         mon(1);
      end else begin
         prev_v[0] = 1'b0;
         prev_v[1] = 1'b0;
      end
   end

   // Called at posedge+2; returns at posedge+2 after the accepting edge.
   task automatic send(input int i, input logic [255:0] a, input logic [255:0] b, input logic sgn);
      int t = 0;
      va[i] = a; vb[i] = b; in_signed[i] = sgn; in_valid[i] = 1'b1;
      @(negedge clk);
      while (!in_ready[i] && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready[i]) begin
         check($sformatf("accept_timeout%0d", i), 64'd0, 64'd1);
         in_valid[i] = 1'b0;
         return;
      end
      @(posedge clk);
      #2;
      acc_cyc[i] = cyc;
      if (i == 0) q0.push_back(model(4, 1'b0, a, b, sgn));
      else        q1.push_back(model(8, 1'b1, a, b, sgn));
      in_valid[i]  = 1'b0;
      va[i]        = {8{$urandom}};
      vb[i]        = {8{$urandom}};
      in_signed[i] = 1'($urandom);
   endtask

   task automatic drain(input int i);
      int t = 0;
      while (((i == 0) ? q0.size() : q1.size()) != 0 && t < 100) begin
         @(posedge clk);
         #2;
         t++;
      end
      if (((i == 0) ? q0.size() : q1.size()) != 0)
         check($sformatf("drain_timeout%0d", i), 64'((i == 0) ? q0.size() : q1.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] a, b, ones;
      logic [31:0]  e;
      int           c0, t, id;

      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid[i] = 1'b0; in_signed[i] = 1'b0; out_ready[i] = 1'b1;
         va[i] = '0; vb[i] = '0; acc_cyc[i] = 0; prev_v[i] = 1'b0;
      end
      ones = '1;
      repeat (3) @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rst_in_ready%0d", i), 64'(in_ready[i]), 64'd1);
         check($sformatf("rst_out_valid%0d", i), 64'(out_valid[i]), 64'd0);
         check($sformatf("rst_result%0d", i), 64'(dot_result[i]), 64'd0);
         check($sformatf("rst_ovf%0d", i), 64'(overflow[i]), 64'd0);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      // Basic, signed, wrap-overflow and saturating cases.
      send(0, pk4(1, 2, 3, 4), pk4(5, 6, 7, 8), 1'b0);                 drain(0);
      send(0, pk4('1, '1, '1, '1), pk4(1, 2, 3, 4), 1'b1);             drain(0);
      send(0, {128'b0, ones[127:0]}, {128'b0, ones[127:0]}, 1'b0);     drain(0);
      send(0, pk4('1, '1, '1, '1), pk4(32'h7FFF_FFFF, 32'h7FFF_FFFF,
                                       32'h7FFF_FFFF, 32'h7FFF_FFFF), 1'b1); drain(0);
      send(1, ones, ones, 1'b0);                                       drain(1);
      send(1, pk4(1, 2, 3, 4), pk4(5, 6, 7, 8), 1'b0);                 drain(1);
      send(1, ones, {8{32'h7FFF_FFFF}}, 1'b1);                         drain(1);
      send(1, {8{32'h0000_4000}}, {8{32'h0000_4000}}, 1'b1);           drain(1);

      // Stall in DONE, then accept the next vector in the handshake cycle.
      out_ready[0] = 1'b0;
      send(0, pk4(1, 2, 3, 4), pk4(1, 1, 1, 1), 1'b0);
      for (int k = 0; k < 4; k++) begin
         check("run_in_ready", 64'(in_ready[0]), 64'd0);
         @(posedge clk);
         #2;
      end
      t = 0;
      while (!out_valid[0] && t < 20) begin
         @(posedge clk);
         #2;
         t++;
      end
      check("stall_valid", 64'(out_valid[0]), 64'd1);
      for (int k = 0; k < 10; k++) begin
         check("stall_in_ready", 64'(in_ready[0]), 64'd0);
         @(posedge clk);
         #2;
      end
      out_ready[0] = 1'b1;
      c0 = cyc;
      send(0, pk4(2, 2, 2, 2), pk4(3, 3, 3, 3), 1'b0);
      check("b2b_accept_cycle", 64'(acc_cyc[0] - c0), 64'd1);
      check("b2b_out_valid", 64'(out_valid[0]), 64'd0);
      check("b2b_in_ready", 64'(in_ready[0]), 64'd0);
      drain(0);

      // Asynchronous reset mid-RUN discards the partial result.
      send(0, pk4(9, 9, 9, 9), pk4(9, 9, 9, 9), 1'b0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      q0.delete();
      check("abort_out_valid", 64'(out_valid[0]), 64'd0);
      check("abort_in_ready", 64'(in_ready[0]), 64'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      send(0, pk4(1, 2, 3, 4), pk4(5, 6, 7, 8), 1'b0);                 drain(0);

      // Random traffic: small signed-range values first, then full-range.
      for (int j = 0; j < 8; j++) begin
         id = j & 1;
         for (int k = 0; k < 8; k++) begin
            if (j < 4) begin
               e = 32'($urandom_range(0, 2000)) - 32'd1000; a[32*k +: 32] = e;
               e = 32'($urandom_range(0, 2000)) - 32'd1000; b[32*k +: 32] = e;
            end else begin
               a[32*k +: 32] = $urandom;
               b[32*k +: 32] = $urandom;
            end
         end
         send(id, a, b, 1'($urandom_range(0, 1)));
         drain(id);
      end

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
